// File: rtl/seg_pkg.sv
// Shared seven-segment constants: glyph table, blank pattern, digit-word layout.
package seg_pkg;

  // Digit word as captured from the switches: {nibble[3:0], dp}
  localparam int unsigned WORD_W  = 5;
  localparam int unsigned DP_BIT  = 0;
  localparam int unsigned NIB_LSB = 1;
  localparam int unsigned NIB_MSB = 4;

  // All segments dark (active-low)
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low hex glyphs, bit0 = a ... bit6 = g
  localparam logic [6:0] SEG_GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,  // 0 1 2 3
    7'h19, 7'h12, 7'h02, 7'h78,  // 4 5 6 7
    7'h00, 7'h10, 7'h08, 7'h03,  // 8 9 A b
    7'h46, 7'h21, 7'h06, 7'h0E   // C d E F
  };

  // Look up the active-low glyph for one hex nibble
  function automatic logic [6:0] hexGlyph(input logic [3:0] nibble);
    return SEG_GLYPH[nibble];
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One raw button: 2-flop synchroniser, stability counter, rising-edge pulse.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic btnRaw,
  output logic rise
);

  localparam int unsigned   CNT_W    = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             syncA;
  logic             syncB;
  logic             stable;
  logic [CNT_W-1:0] cnt;
  logic             settle;

  // Synchronised input has disagreed long enough to be accepted this cycle
  assign settle = (syncB != stable) && (cnt == CNT_LAST);

  // Synchroniser, debounce counter and registered press pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      syncA  <= 1'b0;
      syncB  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
      rise   <= 1'b0;
    end else begin
      syncA <= btnRaw;
      syncB <= syncA;
      rise  <= settle && syncB;
      if (syncB == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt    <= '0;
        stable <= syncB;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/seg_capture_display.sv
// Captures switch values into digit registers on debounced button presses and
// time-multiplexes them onto an active-low seven-segment display.
module seg_capture_display
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned DEBOUNCE_CYC = 250000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4:0]            switches,
  input  logic [NUM_DIGITS-1:0] load_btn,
  input  logic                  blank_en,
  output logic [6:0]            seg_n,
  output logic                  dp_n,
  output logic [NUM_DIGITS-1:0] an_n,
  output logic [NUM_DIGITS-1:0] digit_valid
);

  localparam int unsigned PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [NUM_DIGITS-1:0] risePulse;
  logic [WORD_W-1:0]     digitReg [NUM_DIGITS];
  logic [PRE_W-1:0]      pre;
  logic [IDX_W-1:0]      scanIdx;
  logic [WORD_W-1:0]     activeWord;
  logic                  activeValid;
  logic                  showBlank;
  logic [NUM_DIGITS-1:0] anNext;

  // One debouncer per load button
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : gBtn
    btn_debounce #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) uDebounce (
      .clk    (clk),
      .reset  (reset),
      .btnRaw (load_btn[g]),
      .rise   (risePulse[g])
    );
  end

  // Capture switches into every digit whose button was just pressed
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) digitReg[i] <= '0;
      digit_valid <= '0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (risePulse[i]) begin
          digitReg[i]    <= switches;
          digit_valid[i] <= 1'b1;
        end
      end
    end
  end

  // Refresh prescaler and scan index, advancing one slot per REFRESH_DIV cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      pre     <= '0;
      scanIdx <= '0;
    end else if (pre == PRE_LAST) begin
      pre     <= '0;
      scanIdx <= (scanIdx == IDX_LAST) ? '0 : scanIdx + IDX_W'(1);
    end else begin
      pre <= pre + PRE_W'(1);
    end
  end

  // Select the digit currently being scanned
  always_comb begin
    activeWord  = '0;
    activeValid = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (scanIdx == IDX_W'(i)) begin
        activeWord  = digitReg[i];
        activeValid = digit_valid[i];
      end
    end
  end

  assign showBlank = blank_en && !activeValid;
  assign anNext    = ~(NUM_DIGITS'(1) << scanIdx);

  // Registered display drive; unloaded digits go fully dark when blanking
  always_ff @(posedge clk) begin
    if (reset) begin
      an_n  <= '1;
      seg_n <= SEG_BLANK;
      dp_n  <= 1'b1;
    end else if (showBlank) begin
      an_n  <= '1;
      seg_n <= SEG_BLANK;
      dp_n  <= 1'b1;
    end else begin
      an_n  <= anNext;
      seg_n <= hexGlyph(activeWord[NIB_MSB:NIB_LSB]);
      dp_n  <= ~activeWord[DP_BIT];
    end
  end

endmodule

// File: doc/seg_capture_display.md
SEG_CAPTURE_DISPLAY -- requirements
Module: seg_capture_display

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: digit count, legal 1..8.
REQ-002 SHALL have parameter REFRESH_DIV, default 50000: clk cycles per digit slot, legal >= 2.
REQ-003 SHALL have parameter DEBOUNCE_CYC, default 250000: stable cycles to accept a button change, legal >= 1.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous active-high reset.
REQ-007 SHALL have port switches, input, 5: bit0 = decimal point, bits[4:1] = hex nibble.
REQ-008 SHALL have port load_btn, input, NUM_DIGITS: raw asynchronous buttons; bit i loads digit i.
REQ-009 SHALL have port blank_en, input, 1: 1 = blank digits not loaded since reset.
REQ-010 SHALL have port seg_n, output, 7: active-low segments, bit0 = a ... bit6 = g.
REQ-011 SHALL have port dp_n, output, 1: active-low decimal point.
REQ-012 SHALL have port an_n, output, NUM_DIGITS: active-low anode enables, one-hot-low or all-high.
REQ-013 SHALL have port digit_valid, output, NUM_DIGITS: bit i = digit i loaded since reset.

Function
REQ-014 Each load_btn bit SHALL pass a 2-flop synchroniser and then a debouncer.
REQ-015 Debounced state SHALL change only after the synchronised input differs from it for DEBOUNCE_CYC consecutive cycles; any agreeing cycle clears the count.
REQ-016 On the edge after debounced bit i goes 0->1, digit register i SHALL capture switches and digit_valid[i] SHALL set; held buttons SHALL NOT reload.
REQ-017 Simultaneous rising edges on several buttons SHALL load the same switches value into every affected digit in the same cycle.
REQ-018 Button release and glitches shorter than DEBOUNCE_CYC SHALL have no effect on registers.
REQ-019 Prescaler SHALL count 0..REFRESH_DIV-1 and wrap; at terminal count scan index SHALL advance, wrapping NUM_DIGITS-1 -> 0.
REQ-020 Outputs SHALL be registered: an_n, seg_n, dp_n reflect scan index and digit contents with one-cycle latency.
REQ-021 For active digit i: an_n[i]=0, others 1; seg_n = active-low hex glyph (0-9, A, b, C, d, E, F) of bits[4:1]; dp_n = ~bit0.
REQ-022 If blank_en=1 and digit_valid[i]=0, the slot SHALL drive an_n all-high, seg_n=7'h7F, dp_n=1 (scan timing unchanged).
REQ-023 A load to the currently displayed digit SHALL appear on seg_n/dp_n on the following cycle.
REQ-024 blank_en changes SHALL take effect with the REQ-020 latency, no scan restart.

Reset
REQ-025 On reset: digit registers 0, digit_valid 0, synchronisers/debounced states/debounce counters 0, prescaler 0, scan index 0.
REQ-026 During reset: an_n all-high, seg_n=7'h7F, dp_n=1.
REQ-027 Reset mid-debounce SHALL discard the pending count; a held button SHALL need a full DEBOUNCE_CYC after release of reset to load.
REQ-028 First cycle after reset deassertion SHALL display digit 0 (subject to REQ-022).

Structure
REQ-029 Shared package seg_pkg SHALL hold the 16-entry active-low glyph constant table, SEG_BLANK=7'h7F, and the 5-bit digit-word field positions.
REQ-030 Sub-module btn_debounce (sync + counter + edge pulse, parameter DEBOUNCE_CYC) SHALL be instantiated NUM_DIGITS times via generate.
REQ-031 Counter widths SHALL be derived with $clog2 of their parameters; no hard-coded widths.

Verification (NUM_DIGITS=4, REFRESH_DIV=3, DEBOUNCE_CYC=4)
REQ-032 Reset then idle, blank_en=0: an_n cycles 1110,1101,1011,0111 every 3 cycles, seg_n=7'h40 (glyph 0), dp_n=1.
REQ-033 switches=5'b10101, load_btn[2] high 10 cycles: digit 2 = 0xA, dp lit; slot 2 shows seg_n=7'h08, dp_n=0; digit_valid=0100; single load only.
REQ-034 load_btn[1] pulsed 3 cycles (< DEBOUNCE_CYC): digit_valid and registers unchanged.
REQ-035 load_btn=1111 simultaneously, switches=5'b00110: all digits show glyph 3 (7'h30), digit_valid=1111 same cycle.
REQ-036 blank_en=1 after loading only digit 0: slots 1-3 drive an_n=1111; slot 0 shows loaded glyph.
REQ-037 reset asserted at debounce count 2 with button held: no load; load occurs 4 synchronised cycles after reset release.
